// File: rtl/iob_bus_arb2.sv
// -----------------------------------------------------------------------------
// iob_bus_arb2
// Two-master to one-slave IOb bus arbiter with a single outstanding transaction.
// Master 0 is the instruction port, master 1 the data port.
//
// Ports
//   clk_i, rst_i, cke_i        : clock, synchronous active-high reset, clock enable
//   mN_avalid/addr/wdata/wstrb : master N request (wstrb == 0 means read)
//   mN_ready_o                 : master N request accepted this cycle
//   mN_rvalid_o, mN_rdata_o    : master N read response (rdata is broadcast)
//   s_avalid/addr/wdata/wstrb  : shared slave request
//   s_ready_i, s_rvalid_i,
//   s_rdata_i                  : shared slave response
//   grant_o                    : one-hot current owner, zero when idle
// -----------------------------------------------------------------------------
module iob_bus_arb2 #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned FIXED_PRIO = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cke_i,

   input  logic                  m0_avalid_i,
   input  logic [ADDR_W-1:0]     m0_addr_i,
   input  logic [DATA_W-1:0]     m0_wdata_i,
   input  logic [DATA_W/8-1:0]   m0_wstrb_i,
   output logic                  m0_ready_o,
   output logic                  m0_rvalid_o,
   output logic [DATA_W-1:0]     m0_rdata_o,

   input  logic                  m1_avalid_i,
   input  logic [ADDR_W-1:0]     m1_addr_i,
   input  logic [DATA_W-1:0]     m1_wdata_i,
   input  logic [DATA_W/8-1:0]   m1_wstrb_i,
   output logic                  m1_ready_o,
   output logic                  m1_rvalid_o,
   output logic [DATA_W-1:0]     m1_rdata_o,

   output logic                  s_avalid_o,
   output logic [ADDR_W-1:0]     s_addr_o,
   output logic [DATA_W-1:0]     s_wdata_o,
   output logic [DATA_W/8-1:0]   s_wstrb_o,
   input  logic                  s_ready_i,
   input  logic                  s_rvalid_i,
   input  logic [DATA_W-1:0]     s_rdata_i,

   output logic [1:0]            grant_o
);

   localparam int unsigned STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state;
   logic                owner;       // 0 = m0, 1 = m1
   logic                last_grant;  // master served by the last completed transfer

   logic                pick_c;
   logic                own_avalid_c;
   logic [ADDR_W-1:0]   own_addr_c;
   logic [DATA_W-1:0]   own_wdata_c;
   logic [STRB_W-1:0]   own_wstrb_c;
   logic                in_addr_c;
   logic                in_resp_c;

   // Request fields of the current owner
   always_comb begin
      own_avalid_c = m0_avalid_i;
      own_addr_c   = m0_addr_i;
      own_wdata_c  = m0_wdata_i;
      own_wstrb_c  = m0_wstrb_i;
      if (owner) begin
         own_avalid_c = m1_avalid_i;
         own_addr_c   = m1_addr_i;
         own_wdata_c  = m1_wdata_i;
         own_wstrb_c  = m1_wstrb_i;
      end
   end

   // Arbitration: a lone requester wins; a tie goes to m1 under fixed
   // priority, otherwise to the master that did not win last time
   always_comb begin
      pick_c = 1'b0;
      if (m0_avalid_i && m1_avalid_i) begin
         if (FIXED_PRIO != 0) pick_c = 1'b1;
         else                 pick_c = ~last_grant;
      end else if (m1_avalid_i) begin
         pick_c = 1'b1;
      end
   end

   // Transaction FSM; reset wins over the clock enable
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
      end else if (cke_i) begin
         case (state)
            IDLE: begin
               if (m0_avalid_i || m1_avalid_i) begin
                  owner <= pick_c;
                  state <= ADDR;
               end
            end
            ADDR: begin
               if (s_ready_i) begin
                  last_grant <= owner;
                  state      <= (|own_wstrb_c) ? IDLE : RESP;
               end else if (!own_avalid_c) begin
                  // owner withdrew an unaccepted request: abandon it
                  state <= IDLE;
               end
            end
            RESP: begin
               if (s_rvalid_i) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_addr_c = (state == ADDR);
   assign in_resp_c = (state == RESP);

   // Slave request path: address/data follow the owner, valid and strobes
   // only during the address phase
   assign s_avalid_o = in_addr_c;
   assign s_addr_o   = own_addr_c;
   assign s_wdata_o  = own_wdata_c;
   assign s_wstrb_o  = in_addr_c ? own_wstrb_c : STRB_W'(0);

   // Master handshakes: only the owner sees ready/rvalid
   assign m0_ready_o  = in_addr_c & ~owner & s_ready_i;
   assign m1_ready_o  = in_addr_c &  owner & s_ready_i;
   assign m0_rvalid_o = in_resp_c & ~owner & s_rvalid_i;
   assign m1_rvalid_o = in_resp_c &  owner & s_rvalid_i;

   // Read data is broadcast; rvalid qualifies it
   assign m0_rdata_o = s_rdata_i;
   assign m1_rdata_o = s_rdata_i;

   assign grant_o = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);

endmodule
